mux_reg_n: RTL and testbench

- Parametrised N-channel, W-bit multiplexer with a registered output stage and a valid/ready handshake.
- Next generation of the datapath selector muxes: generalised channel count and width, a round-robin scan mode, and sticky illegal-selector detection.
- Sits between datapath sources (ALU, registers, memory data) and a consumer that can stall, such as the write-back or memory stage of the multicycle CPU.

---
 rtl/mux_pkg.sv | 8 +
 rtl/mux_n_comb.sv | 20 ++
 rtl/mux_reg_n.sv | 65 ++++++
 tb/tb_mux_reg_n.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: shared mode encodings and default datapath sizing for the registered selector mux
package mux_pkg;
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;
    localparam int DEF_WIDTH  = 32;
    localparam int DEF_NUM_CH = 3;
    localparam int DEF_SEL_W  = 3;
endpackage

// File: rtl/mux_n_comb.sv
// mux_n_comb: combinational N:1 mux, out-of-range index falls back to channel 0 and raises illegal
module mux_n_comb #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 3,
    parameter int SEL_W  = 3
) (
    input  logic [NUM_CH*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        data_out,
    output logic                    illegal
);
    // NUM_CH always fits in SEL_W+1 bits because 2**SEL_W >= NUM_CH
    assign illegal = {1'b0, sel} >= (SEL_W+1)'(NUM_CH);
    // channel 0 is the default, so an illegal index forwards it with no extra logic
    always_comb begin
        data_out = data_in[WIDTH-1:0];
        for (int k = 1; k < NUM_CH; k++)
            if (sel == SEL_W'(k)) data_out = data_in[k*WIDTH +: WIDTH];
    end
endmodule

// File: rtl/mux_reg_n.sv
// mux_reg_n: N-channel selector with a registered valid/ready output stage, round-robin scan and sticky illegal-select flag
module mux_reg_n
    import mux_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SEL_W  = DEF_SEL_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        selector,
    input  logic [NUM_CH*WIDTH-1:0] data_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        data_out,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    clear_err,
    output logic                    sel_err
);
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] eff_sel;
    logic [WIDTH-1:0] mux_data;
    logic             illegal;
    logic             started;
    logic             accept;

    assign eff_sel  = (mode == MODE_RR) ? rr_ptr : selector;
    // started holds in_ready low during reset and for the first edge after release
    assign in_ready = started && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    mux_n_comb #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_mux (
        .data_in (data_in),
        .sel     (eff_sel),
        .data_out(mux_data),
        .illegal (illegal)
    );

    // output register, handshake state, scan pointer and sticky error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            started   <= 1'b0;
            data_out  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            started <= 1'b1;
            if (accept) begin
                data_out  <= mux_data;
                out_sel   <= illegal ? '0 : eff_sel;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            sel_err <= (accept && illegal) || (sel_err && !clear_err);
            if (accept && mode == MODE_RR)
                rr_ptr <= (rr_ptr == SEL_W'(NUM_CH-1)) ? '0 : rr_ptr + 1'b1;
        end
    end
endmodule

// File: tb/tb_mux_reg_n.sv
// tb_mux_reg_n: directed-vector bench for the registered selector mux
module tb_mux_reg_n;
    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    logic [2:0]  selector;
    logic [95:0] data_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_out;
    logic [2:0]  out_sel;
    logic        out_valid;
    logic        out_ready;
    logic        clear_err;
    logic        sel_err;
    int checks = 0;
    int failures = 0;
    logic [31:0] ch [3] = '{32'h11111111, 32'h22222222, 32'h33333333};

    mux_reg_n #(.WIDTH(32), .NUM_CH(3), .SEL_W(3)) dut (
        .clk(clk), .reset(reset), .mode(mode), .selector(selector), .data_in(data_in),
        .in_valid(in_valid), .in_ready(in_ready), .data_out(data_out), .out_sel(out_sel),
        .out_valid(out_valid), .out_ready(out_ready), .clear_err(clear_err), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int xfers;
        reset = 1'b1; mode = 1'b0; selector = 3'd0; in_valid = 1'b0;
        out_ready = 1'b1; clear_err = 1'b0;
        data_in = {ch[2], ch[1], ch[0]};
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_sel_err", 32'(sel_err), 32'd0);
        #20 reset = 1'b0;
        cyc();
        check("ready_after_rst", 32'(in_ready), 32'd1);
        // direct select of channel 2
        selector = 3'd2; in_valid = 1'b1;
        cyc();
        check("sel2_data", data_out, 32'h33333333);
        check("sel2_sel", 32'(out_sel), 32'd2);
        check("sel2_valid", 32'(out_valid), 32'd1);
        check("sel2_err", 32'(sel_err), 32'd0);
        // illegal selector forwards channel 0 and sets sticky error
        selector = 3'd5;
        cyc();
        check("ill_data", data_out, 32'h11111111);
        check("ill_sel", 32'(out_sel), 32'd0);
        check("ill_err", 32'(sel_err), 32'd1);
        in_valid = 1'b0;
        cyc();
        check("ill_consumed", 32'(out_valid), 32'd0);
        check("ill_err_sticky", 32'(sel_err), 32'd1);
        clear_err = 1'b1;
        cyc();
        check("err_cleared", 32'(sel_err), 32'd0);
        clear_err = 1'b0;
        // back-pressure holds channel 1
        selector = 3'd1; in_valid = 1'b1;
        cyc();
        check("bp_load", data_out, 32'h22222222);
        out_ready = 1'b0; selector = 3'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            cyc();
            check("bp_hold_data", data_out, 32'h22222222);
            check("bp_hold_sel", 32'(out_sel), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        cyc();
        check("bp_next_data", data_out, 32'h11111111);
        check("bp_next_sel", 32'(out_sel), 32'd0);
        // round-robin scan ignores selector
        mode = 1'b1; selector = 3'd2;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("rr_sel", 32'(out_sel), 32'(i % 3));
            check("rr_data", data_out, ch[i % 3]);
        end
        // full throughput in direct mode
        mode = 1'b0; xfers = 0;
        for (int i = 0; i < 8; i++) begin
            selector = 3'(i % 3);
            cyc();
            check("tp_valid", 32'(out_valid), 32'd1);
            check("tp_data", data_out, ch[i % 3]);
            if (out_valid && out_ready) xfers++;
        end
        check("tp_count", 32'(xfers), 32'd8);
        // load error and advance the pointer, then reset between edges
        selector = 3'd7;
        cyc();
        check("pre_rst_err", 32'(sel_err), 32'd1);
        mode = 1'b1;
        cyc();
        check("pre_rst_rr", 32'(out_sel), 32'd2);
        cyc();
        check("pre_rst_rr2", 32'(out_sel), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data", data_out, 32'd0);
        check("arst_sel", 32'(out_sel), 32'd0);
        check("arst_err", 32'(sel_err), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd0);
        #3 reset = 1'b0;
        cyc();
        check("post_rst_idle", 32'(out_valid), 32'd0);
        cyc();
        check("post_rst_rr0", 32'(out_sel), 32'd0);
        check("post_rst_rr0_data", data_out, 32'h11111111);
        cyc();
        check("post_rst_rr1", 32'(out_sel), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
